// File: rtl/operand_fetch_pkg.sv
// Shared defaults and helpers for the operand-fetch stage and its scoreboard.
package operand_fetch_pkg;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_REG_SEL  = 4;
    localparam int unsigned DEF_NUM_REGS = 16;
    localparam int unsigned DEF_OP_W     = 8;

    // Single-bit lookup into a pending vector; an out-of-range address reads as not pending.
    function automatic logic is_pending(input logic [DEF_NUM_REGS-1:0] vec,
                                        input int unsigned             idx);
        return (idx < DEF_NUM_REGS) ? vec[idx] : 1'b0;
    endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue, cleared on writeback.
module operand_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int unsigned REG_SEL  = DEF_REG_SEL,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en_i,
    input  logic [REG_SEL-1:0]  set_addr_i,
    input  logic                clr_en_i,
    input  logic [REG_SEL-1:0]  clr_addr_i,
    output logic [NUM_REGS-1:0] pending_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Set is applied after clear so a younger writer to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
        if (set_en_i) pending_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives register-bank reads, stalls RAW/WAW hazards, registers operands for execute.
// Define OPFETCH_FORWARD_EN to bypass wb_data into a matching source during the writeback cycle.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned REG_SEL  = DEF_REG_SEL,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned OP_W     = DEF_OP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [REG_SEL-1:0] in_ra,
    input  logic [REG_SEL-1:0] in_rb,
    input  logic [REG_SEL-1:0] in_rz,
    input  logic               in_use_a,
    input  logic               in_use_b,
    input  logic               in_wr,
    output logic [REG_SEL-1:0] rf_addr_a,
    output logic [REG_SEL-1:0] rf_addr_b,
    input  logic [WIDTH-1:0]   rf_data_a,
    input  logic [WIDTH-1:0]   rf_data_b,
    input  logic               wb_valid,
    input  logic [REG_SEL-1:0] wb_addr,
    input  logic [WIDTH-1:0]   wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_op,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [REG_SEL-1:0] out_rz,
    output logic               out_wr
);

    logic [NUM_REGS-1:0] pending;
    logic                hz_a, hz_b, hz_z, hazard, accept;
    logic [WIDTH-1:0]    opnd_a, opnd_b;

    logic               out_valid_q, out_valid_d;
    logic [OP_W-1:0]    out_op_q,    out_op_d;
    logic [WIDTH-1:0]   out_a_q,     out_a_d;
    logic [WIDTH-1:0]   out_b_q,     out_b_d;
    logic [REG_SEL-1:0] out_rz_q,    out_rz_d;
    logic               out_wr_q,    out_wr_d;

    assign rf_addr_a = in_ra;
    assign rf_addr_b = in_rb;

`ifdef OPFETCH_FORWARD_EN
    logic fwd_a, fwd_b;
    assign fwd_a  = wb_valid && (wb_addr == in_ra);
    assign fwd_b  = wb_valid && (wb_addr == in_rb);
    assign hz_a   = in_use_a & pending[in_ra] & ~fwd_a;
    assign hz_b   = in_use_b & pending[in_rb] & ~fwd_b;
    assign opnd_a = fwd_a ? wb_data : rf_data_a;
    assign opnd_b = fwd_b ? wb_data : rf_data_b;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign hz_a   = in_use_a & pending[in_ra];
    assign hz_b   = in_use_b & pending[in_rb];
    assign opnd_a = rf_data_a;
    assign opnd_b = rf_data_b;
`endif

    assign hz_z     = in_wr & pending[in_rz];
    assign hazard   = hz_a | hz_b | hz_z;
    assign in_ready = (~out_valid_q | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;

    operand_scoreboard #(
        .REG_SEL  (REG_SEL),
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (accept & in_wr),
        .set_addr_i (in_rz),
        .clr_en_i   (wb_valid),
        .clr_addr_i (wb_addr),
        .pending_o  (pending)
    );

    always_comb begin
        out_valid_d = out_valid_q & ~out_ready;
        out_op_d    = out_op_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_rz_d    = out_rz_q;
        out_wr_d    = out_wr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_op_d    = in_op;
            out_a_d     = opnd_a;
            out_b_d     = opnd_b;
            out_rz_d    = in_rz;
            out_wr_d    = in_wr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rz_q    <= '0;
            out_wr_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_rz_q    <= out_rz_d;
            out_wr_q    <= out_wr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rz    = out_rz_q;
    assign out_wr    = out_wr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register bank written on wb_valid.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [7:0]  in_op;
    logic [3:0]  in_ra, in_rb, in_rz;
    logic        in_use_a, in_use_b, in_wr;
    logic [3:0]  rf_addr_a, rf_addr_b;
    logic [15:0] rf_data_a, rf_data_b;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_op;
    logic [15:0] out_a, out_b;
    logic [3:0]  out_rz;
    logic        out_wr;

    logic [15:0] rf [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];
    always @(posedge clk) if (wb_valid) rf[wb_addr] <= wb_data;

    operand_fetch #(
        .WIDTH    (16),
        .REG_SEL  (4),
        .NUM_REGS (16),
        .OP_W     (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_rz     (in_rz),
        .in_use_a  (in_use_a),
        .in_use_b  (in_use_b),
        .in_wr     (in_wr),
        .rf_addr_a (rf_addr_a),
        .rf_addr_b (rf_addr_b),
        .rf_data_a (rf_data_a),
        .rf_data_b (rf_data_b),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_rz    (out_rz),
        .out_wr    (out_wr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rz, input logic ua, input logic ub, input logic wr);
        in_valid = 1'b1; in_op = op; in_ra = ra; in_rb = rb; in_rz = rz;
        in_use_a = ua; in_use_b = ub; in_wr = wr;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 16'h0;
        rf[1] = 16'd5; rf[2] = 16'd7; rf[4] = 16'd9; rf[5] = 16'h0055;
        reset = 1'b1; in_valid = 1'b0; in_op = '0; in_ra = '0; in_rb = '0; in_rz = '0;
        in_use_a = 1'b0; in_use_b = 1'b0; in_wr = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        #10 reset = 1'b0;

        // Back-to-back independent instructions
        offer(8'hA1, 4'd1, 4'd2, 4'd3, 1, 1, 1);
        chk("b2b_ready0", in_ready, 1);
        tick();
        chk("b2b_valid0", out_valid, 1);
        chk("b2b_a0", out_a, 16'd5);
        chk("b2b_b0", out_b, 16'd7);
        chk("b2b_rz0", out_rz, 3);
        chk("b2b_wr0", out_wr, 1);
        offer(8'hA2, 4'd4, 4'd4, 4'd0, 1, 1, 0);
        chk("b2b_ready1", in_ready, 1);
        tick();
        chk("b2b_op1", out_op, 8'hA2);
        chk("b2b_a1", out_a, 16'd9);
        chk("b2b_b1", out_b, 16'd9);
        chk("b2b_wr1", out_wr, 0);

        // RAW on R3
        offer(8'hA3, 4'd3, 4'd0, 4'd0, 1, 0, 0);
        chk("raw_stall0", in_ready, 0);
        tick();
        chk("raw_drained", out_valid, 0);
        chk("raw_stall1", in_ready, 0);
        wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
        #1;
`ifdef OPFETCH_FORWARD_EN
        chk("raw_fwd_ready", in_ready, 1);
        tick();
        wb_valid = 1'b0;
`else
        chk("raw_wb_ready", in_ready, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("raw_post_wb_valid", out_valid, 0);
        chk("raw_post_wb_ready", in_ready, 1);
        tick();
`endif
        chk("raw_valid", out_valid, 1);
        chk("raw_op", out_op, 8'hA3);
        chk("raw_a", out_a, 16'h1234);
        in_valid = 1'b0;
        tick();
        chk("raw_idle", out_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        offer(8'hB1, 4'd1, 4'd2, 4'd0, 1, 1, 0);
        tick();
        chk("bp_valid", out_valid, 1);
        offer(8'hB2, 4'd4, 4'd4, 4'd0, 1, 1, 0);
        for (int c = 0; c < 4; c++) begin
            chk("bp_ready", in_ready, 0);
            tick();
            chk("bp_op_hold", out_op, 8'hB1);
            chk("bp_a_hold", out_a, 16'd5);
            chk("bp_valid_hold", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_op2", out_op, 8'hB2);
        chk("bp_a2", out_a, 16'd9);
        offer(8'hB3, 4'd2, 4'd1, 4'd0, 1, 1, 0);
        tick();
        chk("bp_op3", out_op, 8'hB3);
        chk("bp_a3", out_a, 16'd7);
        chk("bp_b3", out_b, 16'd5);
        in_valid = 1'b0;
        tick();

        // Set wins over same-cycle writeback
        offer(8'hC1, 4'd0, 4'd0, 4'd6, 0, 0, 1);
        wb_valid = 1'b1; wb_addr = 4'd6; wb_data = 16'h0066;
        #1;
        chk("sw_ready", in_ready, 1);
        tick();
        wb_valid = 1'b0;
        offer(8'hC2, 4'd6, 4'd0, 4'd0, 1, 0, 0);
        chk("sw_stall0", in_ready, 0);
        tick();
        chk("sw_stall1", in_ready, 0);
        chk("sw_drained", out_valid, 0);
        wb_valid = 1'b1; wb_addr = 4'd6; wb_data = 16'h0777;
        #1;
`ifdef OPFETCH_FORWARD_EN
        chk("sw_fwd_ready", in_ready, 1);
        tick();
        wb_valid = 1'b0;
`else
        chk("sw_wb_ready", in_ready, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("sw_post_wb_ready", in_ready, 1);
        tick();
`endif
        chk("sw_op", out_op, 8'hC2);
        chk("sw_a", out_a, 16'h0777);
        in_valid = 1'b0;
        tick();

        // WAW stall and unused source
        offer(8'hD1, 4'd0, 4'd0, 4'd5, 0, 0, 1);
        tick();
        offer(8'hD2, 4'd0, 4'd0, 4'd5, 0, 0, 1);
        chk("waw_stall", in_ready, 0);
        offer(8'hD3, 4'd5, 4'd1, 4'd5, 0, 1, 0);
        chk("unused_ready", in_ready, 1);
        tick();
        chk("unused_op", out_op, 8'hD3);
        chk("unused_a", out_a, 16'h0055);
        chk("unused_b", out_b, 16'd5);

        // Reset mid-stream with R3 and R5 pending
        offer(8'hE1, 4'd0, 4'd0, 4'd3, 0, 0, 1);
        tick();
        in_valid = 1'b0;
        chk("mid_valid_pre", out_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_op", out_op, 0);
        chk("mid_a", out_a, 0);
        chk("mid_wr", out_wr, 0);
        chk("mid_in_ready", in_ready, 1);
        tick();
        reset = 1'b0;
        offer(8'hE2, 4'd3, 4'd5, 4'd5, 1, 1, 1);
        chk("mid_pending_clear", in_ready, 1);
        tick();
        chk("mid_accept", out_op, 8'hE2);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
